// File: rtl/if_fetch.sv
// Instruction fetch: issues synchronous IM reads and queues returned words in a 2-entry skid buffer for ID.
// Optional macro IF_PERF_CNT_EN adds saturating fetch/stall/redirect counters.
module if_fetch #(
    parameter int          ADDR_W    = 16,
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [16:0] NOP_INSTR = 17'h00000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              im_re,
    output logic [ADDR_W-1:0] im_addr,
    input  logic [16:0]       im_rdata,
    input  logic              stall_IM_ID,
    input  logic              flow_change_ID_EX,
    input  logic [15:0]       dst_ID_EX,
    input  logic              halt,
    output logic [16:0]       instr,
    output logic              instr_vld,
    output logic [15:0]       nxt_pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [15:0]       perf_fetch_cnt,
    output logic [15:0]       perf_stall_cnt,
    output logic [15:0]       perf_redir_cnt
`endif
);

    typedef enum logic {S_RUN, S_HALT} state_t;

    typedef struct packed {
        logic [16:0] ins;
        logic [15:0] pc;
    } entry_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    logic        infl_q, infl_d;
    logic [15:0] infl_pc_q, infl_pc_d;
    entry_t      ent_q [2];
    entry_t      ent_d [2];

    entry_t      ret_e, head_e, tail_e;
    logic [2:0]  total, occ;
    logic        pop, fetch_en;

    // The word returning from IM acts as a virtual tail entry so it reaches ID in its return cycle.
    always_comb begin
        ret_e  = {im_rdata, infl_pc_q};
        head_e = (count_q != 2'd0) ? ent_q[0] : ret_e;
        tail_e = (count_q == 2'd2) ? ent_q[1] : ret_e;
    end

    assign total     = {1'b0, count_q} + {2'b00, infl_q};
    assign instr_vld = (total != 3'd0);
    assign instr     = instr_vld ? head_e.ins : NOP_INSTR;
    assign nxt_pc    = instr_vld ? head_e.pc + 16'd1 : 16'd0;
    assign pop       = instr_vld & ~stall_IM_ID;
    assign occ       = total - {2'b00, pop};
    assign im_addr   = pc_q[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == S_RUN && halt && !flow_change_ID_EX) begin
            state_d = S_HALT;
        end
    end

    always_comb begin
        fetch_en = (state_q == S_RUN);
        im_re    = fetch_en & ~rst & ~flow_change_ID_EX & ~halt & (occ < 3'd2);
    end

    always_comb begin
        pc_d      = pc_q;
        count_d   = occ[1:0];
        infl_d    = im_re;
        infl_pc_d = infl_pc_q;
        ent_d[0]  = pop ? tail_e : head_e;
        ent_d[1]  = tail_e;
        if (im_re) begin
            pc_d      = pc_q + 16'd1;
            infl_pc_d = pc_q;
        end
        // Redirect drops buffered words and forgets the outstanding read; its data is ignored.
        if (flow_change_ID_EX) begin
            pc_d    = dst_ID_EX;
            count_d = 2'd0;
            infl_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            count_q <= 2'd0;
            infl_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            infl_q  <= infl_d;
        end
    end

    always_ff @(posedge clk) begin
        infl_pc_q <= infl_pc_d;
        ent_q     <= ent_d;
    end

`ifdef IF_PERF_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= 16'd0;
            perf_stall_cnt <= 16'd0;
            perf_redir_cnt <= 16'd0;
        end else begin
            if (pop)                      perf_fetch_cnt <= sat_inc(perf_fetch_cnt);
            if (instr_vld && stall_IM_ID) perf_stall_cnt <= sat_inc(perf_stall_cnt);
            if (flow_change_ID_EX)        perf_redir_cnt <= sat_inc(perf_redir_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed timing checks plus a scoreboard of the expected fetch stream.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flow = 1'b0;
    logic [15:0] dst = 16'h0000;
    logic        halt = 1'b0;

    logic        im_re, im_re2;
    logic [15:0] im_addr, im_addr2;
    logic [16:0] im_rdata, im_rdata2;
    logic [16:0] instr, instr2;
    logic        instr_vld, instr_vld2;
    logic [15:0] nxt_pc, nxt_pc2;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [16:0] ins;
        logic [15:0] npc;
    } exp_t;
    exp_t sb[$];

    localparam logic [16:0] NOP = 17'h00000;

`ifdef IF_PERF_CNT_EN
    logic [15:0] pf_fetch, pf_stall, pf_redir, pf_fetch2, pf_stall2, pf_redir2;
`endif

    if_fetch dut (
        .clk(clk), .rst(rst), .im_re(im_re), .im_addr(im_addr), .im_rdata(im_rdata),
        .stall_IM_ID(stall), .flow_change_ID_EX(flow), .dst_ID_EX(dst), .halt(halt),
        .instr(instr), .instr_vld(instr_vld), .nxt_pc(nxt_pc)
`ifdef IF_PERF_CNT_EN
        , .perf_fetch_cnt(pf_fetch), .perf_stall_cnt(pf_stall), .perf_redir_cnt(pf_redir)
`endif
    );

    if_fetch #(.RESET_PC(16'hFFFE)) dut_wrap (
        .clk(clk), .rst(rst), .im_re(im_re2), .im_addr(im_addr2), .im_rdata(im_rdata2),
        .stall_IM_ID(stall), .flow_change_ID_EX(flow), .dst_ID_EX(dst), .halt(halt),
        .instr(instr2), .instr_vld(instr_vld2), .nxt_pc(nxt_pc2)
`ifdef IF_PERF_CNT_EN
        , .perf_fetch_cnt(pf_fetch2), .perf_stall_cnt(pf_stall2), .perf_redir_cnt(pf_redir2)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] im_word(input logic [15:0] a);
        if (a < 16'd4) return 17'h0A001 + {1'b0, a};
        return {1'b1, a};
    endfunction

    // Instruction memory: one-cycle read latency; junk when not read.
    always @(posedge clk) begin
        im_rdata  <= im_re  ? im_word(im_addr)  : 17'h1DEAD;
        im_rdata2 <= im_re2 ? im_word(im_addr2) : 17'h1DEAD;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic seed(input logic [15:0] start);
        sb.delete();
        for (int i = 0; i < 64; i++) begin
            exp_t e;
            logic [15:0] a;
            a = start + 16'(i);
            e.ins = im_word(a);
            e.npc = a + 16'd1;
            sb.push_back(e);
        end
    endtask

    // Scoreboard: every word accepted by ID must be the next one of the current sequential run.
    always @(negedge clk) begin
        if (rst) begin
            seed(16'h0000);
        end else begin
            if (instr_vld && !stall) begin
                if (sb.size() == 0) begin
                    chk_eq("sb_empty", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk_eq("sb_instr", {15'd0, instr}, {15'd0, e.ins});
                    chk_eq("sb_nxtpc", {16'd0, nxt_pc}, {16'd0, e.npc});
                end
            end
            if (flow) seed(dst);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Leaves the bench at cycle 1: rst released, inputs idle.
    task automatic do_reset(input bit check_state);
        next_cycle();
        rst = 1'b1; stall = 1'b0; flow = 1'b0; halt = 1'b0; dst = 16'h0000;
        next_cycle();
        mid();
        if (check_state) begin
            chk_eq("rst_vld",   {31'd0, instr_vld}, 32'd0);
            chk_eq("rst_instr", {15'd0, instr}, {15'd0, NOP});
            chk_eq("rst_nxtpc", {16'd0, nxt_pc}, 32'd0);
            chk_eq("rst_im_re", {31'd0, im_re}, 32'd0);
            chk_eq("rst_addr",  {16'd0, im_addr}, 32'd0);
        end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic chk_head(input string tag, input logic [15:0] a);
        chk_eq({tag, "_vld"},   {31'd0, instr_vld}, 32'd1);
        chk_eq({tag, "_instr"}, {15'd0, instr}, {15'd0, im_word(a)});
        chk_eq({tag, "_nxtpc"}, {16'd0, nxt_pc}, {16'd0, a + 16'd1});
    endtask

    task automatic chk_idle(input string tag);
        chk_eq({tag, "_vld"},   {31'd0, instr_vld}, 32'd0);
        chk_eq({tag, "_instr"}, {15'd0, instr}, {15'd0, NOP});
        chk_eq({tag, "_im_re"}, {31'd0, im_re}, 32'd0);
    endtask

    initial begin
        // Straight-line fetch, plus wrap-around on the FFFE-reset instance
        do_reset(1'b1);
        mid();
        chk_eq("c1_im_re", {31'd0, im_re}, 32'd1);
        chk_eq("c1_addr",  {16'd0, im_addr}, 32'd0);
        chk_eq("c1_vld",   {31'd0, instr_vld}, 32'd0);
        chk_eq("w1_addr",  {16'd0, im_addr2}, 32'h0000FFFE);
        for (int c = 2; c <= 5; c++) begin
            next_cycle();
            mid();
            chk_head("run", 16'(c - 2));
            if (c <= 4) begin
                logic [15:0] w;
                w = 16'hFFFE + 16'(c - 2);
                chk_eq("wrap_vld",   {31'd0, instr_vld2}, 32'd1);
                chk_eq("wrap_instr", {15'd0, instr2}, {15'd0, im_word(w)});
                chk_eq("wrap_nxtpc", {16'd0, nxt_pc2}, {16'd0, w + 16'd1});
            end
        end

        // Stall for 3 cycles with IM[1] at the head
        do_reset(1'b0);
        mid();
        next_cycle(); mid();
        next_cycle(); stall = 1'b1; mid();
        chk_head("stall3", 16'd1);
        chk_eq("stall3_im_re", {31'd0, im_re}, 32'd1);
        for (int c = 4; c <= 5; c++) begin
            next_cycle(); mid();
            chk_head("stallf", 16'd1);
            chk_eq("full_im_re", {31'd0, im_re}, 32'd0);
        end
        next_cycle(); stall = 1'b0; mid();
        chk_head("rel6", 16'd1);
        next_cycle(); mid();
        chk_head("rel7", 16'd2);
        next_cycle(); mid();
        chk_head("rel8", 16'd3);

        // Redirect to 0x40 mid-stream
        do_reset(1'b0);
        mid();
        for (int c = 2; c <= 4; c++) begin
            next_cycle(); mid();
        end
        next_cycle(); flow = 1'b1; dst = 16'h0040; mid();
        chk_eq("redir_noissue", {31'd0, im_re}, 32'd0);
        next_cycle(); flow = 1'b0; mid();
        chk_eq("redir_im_re", {31'd0, im_re}, 32'd1);
        chk_eq("redir_addr",  {16'd0, im_addr}, 32'h40);
        chk_eq("redir_stale", {31'd0, instr_vld}, 32'd0);
        next_cycle(); mid();
        chk_head("redir_tgt", 16'h0040);

        // Halt together with redirect, then halt alone with drain
        do_reset(1'b0);
        mid();
        for (int c = 2; c <= 3; c++) begin
            next_cycle(); mid();
        end
        next_cycle(); flow = 1'b1; halt = 1'b1; dst = 16'h0010; mid();
        next_cycle(); flow = 1'b0; halt = 1'b0; mid();
        chk_eq("hr_im_re", {31'd0, im_re}, 32'd1);
        chk_eq("hr_addr",  {16'd0, im_addr}, 32'h10);
        next_cycle(); mid();
        chk_head("hr_tgt", 16'h0010);
        next_cycle(); mid();
        chk_head("hr_cont", 16'h0011);
        next_cycle(); stall = 1'b1; mid();
        next_cycle(); mid();
        next_cycle(); halt = 1'b1; mid();
        chk_eq("halt_noissue", {31'd0, im_re}, 32'd0);
        next_cycle(); halt = 1'b0; stall = 1'b0; mid();
        chk_head("drain0", 16'h0012);
        chk_eq("drain0_im_re", {31'd0, im_re}, 32'd0);
        next_cycle(); mid();
        chk_head("drain1", 16'h0013);
        chk_eq("drain1_im_re", {31'd0, im_re}, 32'd0);
        for (int c = 0; c < 2; c++) begin
            next_cycle(); mid();
            chk_idle("halted");
        end
        next_cycle(); flow = 1'b1; dst = 16'h0080; mid();
        for (int c = 0; c < 2; c++) begin
            next_cycle(); flow = 1'b0; mid();
            chk_idle("halt_redir");
        end

        // Reset while a read is in flight and the buffer is full
        do_reset(1'b0);
        mid();
        next_cycle(); stall = 1'b1; mid();
        chk_head("rf_c2", 16'd0);
        next_cycle(); mid();
        chk_eq("rf_full", {31'd0, im_re}, 32'd0);
        next_cycle(); rst = 1'b1; mid();
        next_cycle(); rst = 1'b0; stall = 1'b0; mid();
        chk_eq("rf_vld",   {31'd0, instr_vld}, 32'd0);
        chk_eq("rf_instr", {15'd0, instr}, {15'd0, NOP});
        chk_eq("rf_addr",  {16'd0, im_addr}, 32'd0);
        chk_eq("rf_im_re", {31'd0, im_re}, 32'd1);
        next_cycle(); mid();
        chk_head("rf_first", 16'd0);
        next_cycle(); mid();
        chk_head("rf_second", 16'd1);

        next_cycle();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
